// File: rtl/hazard_sched_if.sv
// Hazard-scheduler bundle: the EX/MEM/WB register indices and memory handshake in, stall/flush/forward controls out.
// Purely a wiring bundle; it adds no latency of its own.
// The pipeline side is the master; the scheduler is the slave and answers combinationally.
interface hazard_sched_if #(
  parameter int CNTW = 32
);
  // Pipeline-to-scheduler register indices and control bits
  logic [4:0]      Rs1D, Rs2D;
  logic [4:0]      Rs1E, Rs2E, RdE;
  logic [4:0]      RdM, RdW;
  logic            RegWriteM, RegWriteW;
  logic [1:0]      ResultSrcE;
  logic            PCSrcE;
  logic            MemAccessM;
  logic            MemReadyM;

  // Scheduler-to-pipeline controls and status
  logic            MemReqM;
  logic            StallF, StallD, StallE, StallM;
  logic            FlushD, FlushE, FlushW;
  logic [1:0]      ForwardAE, ForwardBE;
  logic [CNTW-1:0] StallCount, FlushCount;
  logic            MemTimeout;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemAccessM, MemReadyM,
    input  MemReqM, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, StallCount, FlushCount, MemTimeout
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemAccessM, MemReadyM,
    output MemReqM, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, StallCount, FlushCount, MemTimeout
  );
endinterface

// File: rtl/hazard_sched.sv
// Five-stage pipeline hazard scheduler: stalls/flushes, EX forwarding, multi-cycle data-memory wait sequencing.
// All control outputs are combinational (zero latency); counters and the timeout flag update one edge later.
// A pending memory access freezes the whole pipe and defers load-use and branch flushes until MemReadyM.
module hazard_sched #(
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_sched_if.slave bus
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]   WAIT_TOP  = WW'(TIMEOUT);
  localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_MAX   = '1;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   wait_cnt;
  logic [CNTW-1:0] stall_cnt, flush_cnt;
  logic            mem_timeout;

  logic            mem_req;
  logic            mem_stall;
  logic            lw_stall;
  logic            stall_f, stall_d, stall_e, stall_m;
  logic            flush_d, flush_e, flush_w;
  logic [1:0]      fwd_a, fwd_b;

  // State register for the memory-wait sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, memory request and stall/flush decode
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_stall = 1'b0;
    lw_stall  = 1'b0;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_w   = 1'b0;

    // In MEMWAIT the MEM stage is frozen, so the held request stays up
    // regardless of what MemAccessM shows.
    case (state)
      RUN: begin
        mem_req = bus.MemAccessM;
        if (bus.MemAccessM && !bus.MemReadyM) begin
          state_nxt = MEMWAIT;
        end
      end
      MEMWAIT: begin
        mem_req = 1'b1;
        if (bus.MemReadyM) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase

    mem_stall = mem_req && !bus.MemReadyM;

    if (mem_stall) begin
      // Freeze everything up to MEM and bubble WB. ID/EX is held, so any
      // load-use or redirect is seen again once memory releases the pipe.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      lw_stall = (bus.ResultSrcE == 2'b01) && (bus.RdE != 5'd0) &&
                 ((bus.Rs1D == bus.RdE) || (bus.Rs2D == bus.RdE));
      stall_f  = lw_stall;
      stall_d  = lw_stall;
      flush_d  = bus.PCSrcE;
      flush_e  = bus.PCSrcE || lw_stall;
    end
  end

  // EX operand forwarding; MEM is the younger producer so it wins over WB
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;

    if (bus.RegWriteM && (bus.RdM != 5'd0) && (bus.RdM == bus.Rs1E)) begin
      fwd_a = 2'b10;
    end else if (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == bus.Rs1E)) begin
      fwd_a = 2'b01;
    end

    if (bus.RegWriteM && (bus.RdM != 5'd0) && (bus.RdM == bus.Rs2E)) begin
      fwd_b = 2'b10;
    end else if (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == bus.Rs2E)) begin
      fwd_b = 2'b01;
    end
  end

  // Wait-cycle counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (state == RUN) begin
        if (state_nxt == MEMWAIT) begin
          wait_cnt <= '0;
        end
      end else if (wait_cnt != WAIT_TOP) begin
        wait_cnt <= wait_cnt + WW'(1);
      end

      // Flag rises on the same edge the counter reaches TIMEOUT; the
      // stall itself is unaffected and keeps waiting for ready.
      if ((state == MEMWAIT) && (wait_cnt == WAIT_LAST)) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  // Saturating stall and flush performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNTW'(1);
      end
      if (flush_d && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNTW'(1);
      end
    end
  end

  // Drive the bundle outputs
  always_comb begin
    bus.MemReqM    = mem_req;
    bus.StallF     = stall_f;
    bus.StallD     = stall_d;
    bus.StallE     = stall_e;
    bus.StallM     = stall_m;
    bus.FlushD     = flush_d;
    bus.FlushE     = flush_e;
    bus.FlushW     = flush_w;
    bus.ForwardAE  = fwd_a;
    bus.ForwardBE  = fwd_b;
    bus.StallCount = stall_cnt;
    bus.FlushCount = flush_cnt;
    bus.MemTimeout = mem_timeout;
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: table of combinational hazard vectors plus
// hand-written memory-wait, timeout/precedence and reset-abort sequences.
// Built with TIMEOUT=4 so the timeout path is reached in a few cycles.
module tb_hazard_sched;

  localparam int CNTW = 32;

  logic clk;
  logic rst;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_sched_if #(.CNTW(CNTW)) hif ();

  hazard_sched #(.TIMEOUT(4), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww;
    logic [1:0] rsrc;
    logic       pcsrc;
    logic [1:0] exp_fa, exp_fb;
    logic       exp_sf, exp_sd, exp_fd, exp_fe;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    hif.Rs1D = '0; hif.Rs2D = '0; hif.Rs1E = '0; hif.Rs2E = '0;
    hif.RdE = '0; hif.RdM = '0; hif.RdW = '0;
    hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
    hif.ResultSrcE = 2'b00; hif.PCSrcE = 1'b0;
    hif.MemAccessM = 1'b0; hif.MemReadyM = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // Full memory-stall pattern: all four stalls and FlushW high, D/E flushes low
  task automatic chk_memstall(input string tag, input logic exp);
    chk({tag, "_StallF"}, 64'(hif.StallF), 64'(exp));
    chk({tag, "_StallD"}, 64'(hif.StallD), 64'(exp));
    chk({tag, "_StallE"}, 64'(hif.StallE), 64'(exp));
    chk({tag, "_StallM"}, 64'(hif.StallM), 64'(exp));
    chk({tag, "_FlushW"}, 64'(hif.FlushW), 64'(exp));
  endtask

  initial begin
    //                 rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rsrc  pc  fa     fb     sf sd fd fe
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd7, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd7, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'd0, 5'd0, 5'd5, 5'd7, 5'd0, 5'd7, 5'd5, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd7, 5'd7, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{5'd1, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{5'd0, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{5'd4, 5'd9, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1;
    clear_inputs();
    #2;
    chk("rst_StallCount", 64'(hif.StallCount), 64'd0);
    chk("rst_FlushCount", 64'(hif.FlushCount), 64'd0);
    chk("rst_MemTimeout", 64'(hif.MemTimeout), 64'd0);
    chk("rst_MemReqM",    64'(hif.MemReqM),    64'd0);
    tick();
    rst = 1'b0;

    // Combinational hazard/forward table, all in RUN with no memory access
    for (int i = 0; i < 11; i++) begin
      hif.Rs1D = vecs[i].rs1d; hif.Rs2D = vecs[i].rs2d;
      hif.Rs1E = vecs[i].rs1e; hif.Rs2E = vecs[i].rs2e;
      hif.RdE = vecs[i].rde; hif.RdM = vecs[i].rdm; hif.RdW = vecs[i].rdw;
      hif.RegWriteM = vecs[i].rwm; hif.RegWriteW = vecs[i].rww;
      hif.ResultSrcE = vecs[i].rsrc; hif.PCSrcE = vecs[i].pcsrc;
      #2;
      chk($sformatf("v%0d_ForwardAE", i), 64'(hif.ForwardAE), 64'(vecs[i].exp_fa));
      chk($sformatf("v%0d_ForwardBE", i), 64'(hif.ForwardBE), 64'(vecs[i].exp_fb));
      chk($sformatf("v%0d_StallF", i),    64'(hif.StallF),    64'(vecs[i].exp_sf));
      chk($sformatf("v%0d_StallD", i),    64'(hif.StallD),    64'(vecs[i].exp_sd));
      chk($sformatf("v%0d_FlushD", i),    64'(hif.FlushD),    64'(vecs[i].exp_fd));
      chk($sformatf("v%0d_FlushE", i),    64'(hif.FlushE),    64'(vecs[i].exp_fe));
      chk($sformatf("v%0d_StallE", i),    64'(hif.StallE),    64'd0);
      chk($sformatf("v%0d_FlushW", i),    64'(hif.FlushW),    64'd0);
      tick();
    end

    // Load-use bumps StallCount by one per cycle
    clear_inputs();
    pulse_reset();
    hif.ResultSrcE = 2'b01; hif.RdE = 5'd3; hif.Rs2D = 5'd3;
    #1;
    chk("lu_cnt_before", 64'(hif.StallCount), 64'd0);
    tick();
    clear_inputs();
    #1;
    chk("lu_cnt_after", 64'(hif.StallCount), 64'd1);
    chk("lu_flushcnt",  64'(hif.FlushCount), 64'd0);

    // Branch bumps FlushCount by one
    hif.PCSrcE = 1'b1;
    #1;
    chk("br_StallF", 64'(hif.StallF), 64'd0);
    tick();
    clear_inputs();
    #1;
    chk("br_flushcnt", 64'(hif.FlushCount), 64'd1);
    chk("br_stallcnt", 64'(hif.StallCount), 64'd1);

    // Zero-wait access: no stall, stays in RUN
    pulse_reset();
    hif.MemAccessM = 1'b1; hif.MemReadyM = 1'b1;
    #1;
    chk("zw_MemReqM", 64'(hif.MemReqM), 64'd1);
    chk("zw_StallF",  64'(hif.StallF),  64'd0);
    tick();
    hif.MemAccessM = 1'b0; hif.MemReadyM = 1'b0;
    #1;
    chk("zw_MemReqM_after", 64'(hif.MemReqM), 64'd0);
    chk("zw_stallcnt",      64'(hif.StallCount), 64'd0);

    // Three-cycle memory wait, ready on the fourth request cycle
    tick();
    hif.MemAccessM = 1'b1; hif.MemReadyM = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("mw%0d_MemReqM", c), 64'(hif.MemReqM), 64'd1);
      chk_memstall($sformatf("mw%0d", c), 1'b1);
      chk($sformatf("mw%0d_FlushE", c), 64'(hif.FlushE), 64'd0);
      tick();
      hif.MemAccessM = 1'b0;  // ignored while waiting
    end
    hif.MemReadyM = 1'b1;
    #1;
    chk("mw4_MemReqM", 64'(hif.MemReqM), 64'd1);
    chk_memstall("mw4", 1'b0);
    tick();
    hif.MemReadyM = 1'b0;
    #1;
    chk("mw5_MemReqM",   64'(hif.MemReqM),    64'd0);
    chk("mw5_stallcnt",  64'(hif.StallCount), 64'd3);
    chk("mw5_timeout",   64'(hif.MemTimeout), 64'd0);

    // Timeout with a branch pending during the wait
    pulse_reset();
    hif.MemAccessM = 1'b1; hif.MemReadyM = 1'b0; hif.PCSrcE = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk($sformatf("to%0d_FlushD", k), 64'(hif.FlushD), 64'd0);
      chk($sformatf("to%0d_StallF", k), 64'(hif.StallF), 64'd1);
      tick();
      if (k == 3) chk("to_flag_early", 64'(hif.MemTimeout), 64'd0);
      if (k == 5) chk("to_flag_set",   64'(hif.MemTimeout), 64'd1);
    end
    hif.MemReadyM = 1'b1;
    #1;
    chk("to_rel_StallF",  64'(hif.StallF), 64'd0);
    chk("to_rel_FlushD",  64'(hif.FlushD), 64'd1);
    chk("to_rel_FlushE",  64'(hif.FlushE), 64'd1);
    tick();
    clear_inputs();
    #1;
    chk("to_sticky",    64'(hif.MemTimeout), 64'd1);
    chk("to_flushcnt",  64'(hif.FlushCount), 64'd1);
    chk("to_stallcnt",  64'(hif.StallCount), 64'd6);
    chk("to_MemReqM",   64'(hif.MemReqM),    64'd0);

    // Reset aborts a long wait: state, counters and flag clear immediately
    pulse_reset();
    hif.MemAccessM = 1'b1; hif.MemReadyM = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    hif.MemAccessM = 1'b0;
    #1;
    chk("ra_pre_MemReqM",  64'(hif.MemReqM),    64'd1);
    chk("ra_pre_timeout",  64'(hif.MemTimeout), 64'd1);
    rst = 1'b1;
    #1;
    chk("ra_MemReqM",     64'(hif.MemReqM),    64'd0);
    chk("ra_StallF",      64'(hif.StallF),     64'd0);
    chk("ra_stallcnt",    64'(hif.StallCount), 64'd0);
    chk("ra_flushcnt",    64'(hif.FlushCount), 64'd0);
    chk("ra_timeout",     64'(hif.MemTimeout), 64'd0);
    rst = 1'b0;
    tick();
    #1;
    chk("ra_post_MemReqM", 64'(hif.MemReqM), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
